// File: rtl/instr_mem_bridge.sv
// instr_mem_bridge: slave on the core's instruction fetch port (req/gnt/valid)
// driving a single-port synchronous instruction SRAM with one-cycle read latency.
// A programmable grant delay and response latency let the fetch stage see
// stalls and long fetches. Misaligned or out-of-range fetches return an error.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   instr_req/addr      fetch request and byte address
//   instr_gnt           request accepted this cycle (combinational)
//   instr_valid/err     single-cycle response pulse and error flag
//   instr_rdata         response data, 0 unless a good response is valid
//   mem_busy            SRAM claimed by the data-port arbiter this cycle
//   mem_cs/mem_addr     SRAM read strobe and word index
//   mem_rdata           SRAM data, valid the cycle after mem_cs
//   outstanding         granted requests still awaiting their response
//
// MEM_BASE is assumed word aligned; MEM_WORDS is a power of two below 2**30.

module instr_mem_bridge_chk #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int OW              = 2
) (
  input logic          clk,
  input logic          reset_n,
  input logic          instr_gnt,
  input logic          instr_valid,
  input logic          mem_cs,
  input logic [OW-1:0] outstanding
);

  // A response can only retire a request that was actually granted.
  a_valid_has_owner: assert property (@(posedge clk) disable iff (!reset_n)
    instr_valid |-> (outstanding != '0));

  // The SRAM is only strobed for an accepted request.
  a_cs_needs_gnt: assert property (@(posedge clk) disable iff (!reset_n)
    mem_cs |-> instr_gnt);

  // The in-flight count never passes its ceiling.
  a_out_bounded: assert property (@(posedge clk) disable iff (!reset_n)
    outstanding <= OW'(MAX_OUTSTANDING));

endmodule

module instr_mem_bridge #(
  parameter logic [31:0] MEM_BASE        = 32'h0000_0000,
  parameter int          MEM_WORDS       = 4096,
  parameter int          GNT_DELAY       = 0,
  parameter int          RSP_LATENCY     = 1,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic                                 instr_req,
  input  logic [31:0]                          instr_addr,
  output logic                                 instr_gnt,
  output logic [31:0]                          instr_rdata,
  output logic                                 instr_err,
  output logic                                 instr_valid,
  input  logic                                 mem_busy,
  output logic                                 mem_cs,
  output logic [$clog2(MEM_WORDS)-1:0]         mem_addr,
  input  logic [31:0]                          mem_rdata,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int GW = (GNT_DELAY > 0) ? $clog2(GNT_DELAY + 1) : 1;

  logic [GW-1:0] gcnt_r;
  logic [OW-1:0] out_r;
  logic [30:0]   word_diff_s;
  logic          bad_s;
  logic          gnt_s;
  logic          cs_s;
  logic [AW-1:0] maddr_s;
  logic          v0_r;
  logic          e0_r;
  logic [31:0]   d0_s;
  logic          last_v_s;
  logic          last_e_s;
  logic [31:0]   last_d_s;

  // Address check and grant decision for the current request.
  always_comb begin
    // Word-granular difference with an extra borrow bit: an address below
    // MEM_BASE sets bit 30 instead of wrapping into the valid window.
    word_diff_s = {1'b0, instr_addr[31:2]} - {1'b0, MEM_BASE[31:2]};
    bad_s = (instr_addr[1:0] != 2'b00) | word_diff_s[30] | (|word_diff_s[29:AW]);
    // A response retiring this cycle frees its slot for a new grant.
    gnt_s = instr_req & (gcnt_r == GW'(GNT_DELAY)) & ~mem_busy &
            ((out_r < OW'(MAX_OUTSTANDING)) | last_v_s);
    cs_s  = gnt_s & ~bad_s;
    if (cs_s) begin
      maddr_s = word_diff_s[AW-1:0];
    end else begin
      maddr_s = '0;
    end
  end

  // Grant-delay counter: counts waiting cycles, saturating at GNT_DELAY so a
  // busy SRAM leaves the request ready to go the first free cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gcnt_r <= '0;
    end else if (instr_req && !gnt_s) begin
      if (gcnt_r != GW'(GNT_DELAY)) begin
        gcnt_r <= gcnt_r + GW'(1);
      end else begin
        gcnt_r <= gcnt_r;
      end
    end else begin
      gcnt_r <= '0;
    end
  end

  // In-flight counter: up on grant, down on response, unchanged on both.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_r <= '0;
    end else begin
      case ({gnt_s, last_v_s})
        2'b10:   out_r <= out_r + OW'(1);
        2'b01:   out_r <= out_r - OW'(1);
        default: out_r <= out_r;
      endcase
    end
  end

  // First response stage: tags the cycle in which the SRAM data arrives.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v0_r <= 1'b0;
      e0_r <= 1'b0;
    end else begin
      v0_r <= gnt_s;
      e0_r <= gnt_s & bad_s;
    end
  end

  // The SRAM data is only meaningful for a good response in flight.
  assign d0_s = (v0_r & ~e0_r) ? mem_rdata : 32'h0000_0000;

  generate
    if (RSP_LATENCY == 1) begin : g_lat1
      assign last_v_s = v0_r;
      assign last_e_s = e0_r;
      assign last_d_s = d0_s;
    end else begin : g_latn
      localparam int NS = RSP_LATENCY - 1;
      logic [NS-1:0] v_r;
      logic [NS-1:0] e_r;
      logic [31:0]   d_r [NS];

      // Fixed-delay shift of responses; the fetch port has no back-pressure.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          v_r <= '0;
          e_r <= '0;
          for (int i = 0; i < NS; i++) begin
            d_r[i] <= 32'h0000_0000;
          end
        end else begin
          v_r[0] <= v0_r;
          e_r[0] <= e0_r;
          d_r[0] <= d0_s;
          for (int i = 1; i < NS; i++) begin
            v_r[i] <= v_r[i-1];
            e_r[i] <= e_r[i-1];
            d_r[i] <= d_r[i-1];
          end
        end
      end

      assign last_v_s = v_r[NS-1];
      assign last_e_s = e_r[NS-1];
      assign last_d_s = d_r[NS-1];
    end
  endgenerate

  assign instr_gnt   = gnt_s;
  assign mem_cs      = cs_s;
  assign mem_addr    = maddr_s;
  assign outstanding = out_r;
  assign instr_valid = last_v_s;
  assign instr_err   = last_e_s;
  assign instr_rdata = last_d_s;

  instr_mem_bridge_chk #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING),
    .OW              (OW)
  ) u_chk (
    .clk         (clk),
    .reset_n     (reset_n),
    .instr_gnt   (gnt_s),
    .instr_valid (last_v_s),
    .mem_cs      (cs_s),
    .outstanding (out_r)
  );

endmodule

// File: tb/tb_instr_mem_bridge.sv
module tb_instr_mem_bridge;

  // Three bridges: defaults, GNT_DELAY=2, and MEM_BASE=0x1000 / RSP_LATENCY=3.
  localparam int PD [3] = '{0, 2, 0};
  localparam int PL [3] = '{1, 1, 3};
  localparam int PM [3] = '{2, 2, 2};
  localparam int PB [3] = '{32'h0, 32'h0, 32'h1000};

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req   [3];
  logic [31:0] addr  [3];
  logic        busy  [3];
  logic        gnt   [3];
  logic        err   [3];
  logic        valid [3];
  logic        cs    [3];
  logic [31:0] rdata [3];
  logic [31:0] mrdata[3];
  logic [11:0] maddr [3];
  logic [1:0]  outs  [3];

  logic [31:0] smem [4096];

  int vecs = 0;
  int miss = 0;

  // reference model state: pending responses scheduled by due cycle
  int          mcyc = 0;
  int          wcnt [3];
  int          mout [3];
  logic        sv   [3][64];
  logic        se   [3][64];
  logic [31:0] sd   [3][64];
  logic [49:0] ev   [3];

  always #5 clk = ~clk;

  instr_mem_bridge #(.GNT_DELAY(0)) u0 (
    .clk(clk), .reset_n(reset_n), .instr_req(req[0]), .instr_addr(addr[0]),
    .instr_gnt(gnt[0]), .instr_rdata(rdata[0]), .instr_err(err[0]), .instr_valid(valid[0]),
    .mem_busy(busy[0]), .mem_cs(cs[0]), .mem_addr(maddr[0]), .mem_rdata(mrdata[0]),
    .outstanding(outs[0]));

  instr_mem_bridge #(.GNT_DELAY(2)) u1 (
    .clk(clk), .reset_n(reset_n), .instr_req(req[1]), .instr_addr(addr[1]),
    .instr_gnt(gnt[1]), .instr_rdata(rdata[1]), .instr_err(err[1]), .instr_valid(valid[1]),
    .mem_busy(busy[1]), .mem_cs(cs[1]), .mem_addr(maddr[1]), .mem_rdata(mrdata[1]),
    .outstanding(outs[1]));

  instr_mem_bridge #(.MEM_BASE(32'h0000_1000), .RSP_LATENCY(3), .MAX_OUTSTANDING(2)) u2 (
    .clk(clk), .reset_n(reset_n), .instr_req(req[2]), .instr_addr(addr[2]),
    .instr_gnt(gnt[2]), .instr_rdata(rdata[2]), .instr_err(err[2]), .instr_valid(valid[2]),
    .mem_busy(busy[2]), .mem_cs(cs[2]), .mem_addr(maddr[2]), .mem_rdata(mrdata[2]),
    .outstanding(outs[2]));

  // SRAM models: one-cycle read; garbage on cycles without a read strobe
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      mrdata[k] <= cs[k] ? smem[maddr[k]] : $urandom;
    end
  end

  function automatic logic [49:0] act(input int k);
    return {gnt[k], cs[k], maddr[k], valid[k], err[k], rdata[k], outs[k]};
  endfunction

  // Predict this cycle's outputs from the rules, then advance model state.
  task automatic predict();
    longint a, b;
    logic   e_gnt, e_cs, e_valid, e_err, bad;
    logic [31:0] e_data;
    longint e_ma;
    int slot, due;
    for (int k = 0; k < 3; k++) begin
      if (!reset_n) begin
        ev[k]   = '0;
        wcnt[k] = 0;
        mout[k] = 0;
        for (int s = 0; s < 64; s++) begin
          sv[k][s] = 1'b0; se[k][s] = 1'b0; sd[k][s] = 32'h0;
        end
      end else begin
        slot    = mcyc % 64;
        e_valid = sv[k][slot];
        e_err   = se[k][slot];
        e_data  = sd[k][slot];
        e_gnt   = req[k] && (wcnt[k] == PD[k]) && !busy[k] && ((mout[k] < PM[k]) || e_valid);
        a       = longint'(addr[k]);
        b       = longint'(PB[k]);
        bad     = (a % 4 != 0) || (a < b) || ((a - b) / 4 >= 4096);
        e_cs    = e_gnt && !bad;
        e_ma    = e_cs ? (a - b) / 4 : 0;
        ev[k]   = {e_gnt, e_cs, 12'(e_ma), e_valid, e_err, e_data, 2'(mout[k])};
        if (e_valid) begin
          sv[k][slot] = 1'b0; se[k][slot] = 1'b0; sd[k][slot] = 32'h0;
          mout[k]--;
        end
        if (e_gnt) begin
          due = (mcyc + PL[k]) % 64;
          sv[k][due] = 1'b1;
          se[k][due] = bad;
          sd[k][due] = bad ? 32'h0 : smem[int'((a - b) / 4)];
          mout[k]++;
        end
        if (req[k] && !e_gnt) wcnt[k] = (wcnt[k] < PD[k]) ? wcnt[k] + 1 : wcnt[k];
        else wcnt[k] = 0;
      end
    end
    mcyc++;
  endtask

  task automatic sample();
    @(negedge clk);
    predict();
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    for (int k = 0; k < 3; k++) begin
      req[k] = 1'b0; busy[k] = 1'b0; addr[k] = 32'h0;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle_all();
    for (int c = 0; c < 3; c++) begin
      sample();
      for (int k = 0; k < 3; k++) begin
        vecs++;
        if (act(k) !== ev[k]) begin
          $display("FAIL reset u%0d: got %h expected %h", k, act(k), ev[k]); miss++;
        end
        vecs++;
        if ({valid[k], outs[k], gnt[k], cs[k]} !== 5'b0) begin
          $display("FAIL reset_zero u%0d: got valid=%b out=%0d gnt=%b cs=%b expected all 0",
                   k, valid[k], outs[k], gnt[k], cs[k]); miss++;
        end
      end
      next_cycle();
    end
    reset_n = 1'b1;
  endtask

  task automatic test_single();
    req[0] = 1'b1; addr[0] = 32'h0000_0010;
    sample();
    for (int k = 0; k < 3; k++) begin
      vecs++;
      if (act(k) !== ev[k]) begin
        $display("FAIL single u%0d: got %h expected %h", k, act(k), ev[k]); miss++;
      end
    end
    vecs++;
    if ({gnt[0], cs[0], maddr[0]} !== {1'b1, 1'b1, 12'd4}) begin
      $display("FAIL single_req: got gnt=%b cs=%b maddr=%0d expected 1 1 4", gnt[0], cs[0], maddr[0]);
      miss++;
    end
    next_cycle();
    req[0] = 1'b0;
    sample();
    for (int k = 0; k < 3; k++) begin
      vecs++;
      if (act(k) !== ev[k]) begin
        $display("FAIL single u%0d: got %h expected %h", k, act(k), ev[k]); miss++;
      end
    end
    vecs++;
    if ({valid[0], err[0], rdata[0]} !== {1'b1, 1'b0, 32'hDEAD_BEEF}) begin
      $display("FAIL single_rsp: got valid=%b err=%b rdata=%h expected 1 0 deadbeef",
               valid[0], err[0], rdata[0]); miss++;
    end
    next_cycle();
  endtask

  task automatic test_stream();
    for (int i = 0; i < 6; i++) begin
      req[0]  = (i < 4);
      addr[0] = 32'(4 * i);
      sample();
      for (int k = 0; k < 3; k++) begin
        vecs++;
        if (act(k) !== ev[k]) begin
          $display("FAIL stream u%0d: got %h expected %h", k, act(k), ev[k]); miss++;
        end
      end
      vecs++;
      if (outs[0] > 2'd1 || (i < 4 && gnt[0] !== 1'b1) || (i >= 1 && i < 5 && valid[0] !== 1'b1)) begin
        $display("FAIL stream_flow: cycle %0d got gnt=%b valid=%b out=%0d expected gnt/valid each cycle, out<=1",
                 i, gnt[0], valid[0], outs[0]); miss++;
      end
      next_cycle();
    end
    idle_all();
  endtask

  task automatic test_gnt_delay();
    for (int i = 0; i < 4; i++) begin
      req[1]  = (i < 3);
      addr[1] = (i == 0) ? 32'h20 : 32'h40;
      sample();
      for (int k = 0; k < 3; k++) begin
        vecs++;
        if (act(k) !== ev[k]) begin
          $display("FAIL gnt_delay u%0d: got %h expected %h", k, act(k), ev[k]); miss++;
        end
      end
      vecs++;
      if (gnt[1] !== (i == 2) || (i == 2 && maddr[1] !== 12'd16) ||
          (i == 3 && {valid[1], rdata[1]} !== {1'b1, smem[16]})) begin
        $display("FAIL gnt_delay_seq: cycle %0d got gnt=%b maddr=%0d valid=%b rdata=%h expected gnt on 3rd, word 16=%h",
                 i, gnt[1], maddr[1], valid[1], rdata[1], smem[16]); miss++;
      end
      next_cycle();
    end
    idle_all();
  endtask

  task automatic test_busy();
    for (int i = 0; i < 5; i++) begin
      req[0]  = (i < 4);
      busy[0] = (i < 3);
      addr[0] = 32'h80;
      sample();
      for (int k = 0; k < 3; k++) begin
        vecs++;
        if (act(k) !== ev[k]) begin
          $display("FAIL busy u%0d: got %h expected %h", k, act(k), ev[k]); miss++;
        end
      end
      vecs++;
      if ((i < 3 && {gnt[0], cs[0]} !== 2'b00) || (i == 3 && {gnt[0], cs[0]} !== 2'b11)) begin
        $display("FAIL busy_gnt: cycle %0d got gnt=%b cs=%b", i, gnt[0], cs[0]); miss++;
      end
      next_cycle();
    end
    idle_all();
  endtask

  task automatic test_errors();
    int          ek [3];
    logic [31:0] ea [3];
    ek = '{0, 0, 2};
    ea = '{32'h0000_0002, 32'h0000_4000, 32'hFFFF_FFFC};
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i <= PL[ek[t]]; i++) begin
        req[ek[t]]  = (i == 0);
        addr[ek[t]] = ea[t];
        sample();
        for (int k = 0; k < 3; k++) begin
          vecs++;
          if (act(k) !== ev[k]) begin
            $display("FAIL error u%0d: got %h expected %h", k, act(k), ev[k]); miss++;
          end
        end
        vecs++;
        if (cs[ek[t]] !== 1'b0 || (i == 0 && gnt[ek[t]] !== 1'b1) ||
            (i == PL[ek[t]] && {valid[ek[t]], err[ek[t]], rdata[ek[t]]} !== {1'b1, 1'b1, 32'h0})) begin
          $display("FAIL error_rsp: addr %h step %0d got cs=%b valid=%b err=%b rdata=%h expected err response",
                   ea[t], i, cs[ek[t]], valid[ek[t]], err[ek[t]], rdata[ek[t]]); miss++;
        end
        next_cycle();
      end
      idle_all();
    end
  endtask

  task automatic test_back_to_back();
    int ng = 0, maxo = 0, stalls = 0;
    for (int c = 0; c < 16; c++) begin
      req[2]  = (ng < 5);
      addr[2] = 32'h1000 + 32'(4 * ng);
      sample();
      for (int k = 0; k < 3; k++) begin
        vecs++;
        if (act(k) !== ev[k]) begin
          $display("FAIL b2b u%0d: got %h expected %h", k, act(k), ev[k]); miss++;
        end
      end
      if (int'(outs[2]) > maxo) maxo = int'(outs[2]);
      if (req[2] && !gnt[2]) stalls++;
      vecs++;
      if (req[2] && outs[2] == 2'd2 && gnt[2] !== valid[2]) begin
        $display("FAIL b2b_resume: cycle %0d got gnt=%b valid=%b expected gnt with retiring valid",
                 c, gnt[2], valid[2]); miss++;
      end
      if (gnt[2]) ng++;
      next_cycle();
    end
    vecs++;
    if (ng != 5 || maxo != 2 || stalls == 0) begin
      $display("FAIL b2b_summary: got grants=%0d max_out=%0d stalls=%0d expected 5 2 >0", ng, maxo, stalls);
      miss++;
    end
    idle_all();
  endtask

  task automatic test_reset_flight();
    for (int c = 0; c < 11; c++) begin
      req[2]  = (c < 2);
      addr[2] = 32'h1000 + 32'(4 * c);
      reset_n = !(c == 3 || c == 4);
      sample();
      for (int k = 0; k < 3; k++) begin
        vecs++;
        if (act(k) !== ev[k]) begin
          $display("FAIL reset_flight u%0d: got %h expected %h", k, act(k), ev[k]); miss++;
        end
      end
      vecs++;
      if ((c == 2 && outs[2] !== 2'd2) || (c >= 3 && {valid[2], outs[2]} !== 3'b000)) begin
        $display("FAIL reset_flight_chk: cycle %0d got valid=%b out=%0d", c, valid[2], outs[2]); miss++;
      end
      next_cycle();
    end
    reset_n = 1'b1;
    idle_all();
  endtask

  task automatic test_random();
    int r;
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < 3; k++) begin
        req[k]  = (c < 390) && ($urandom_range(0, 3) != 0);
        busy[k] = ($urandom_range(0, 4) == 0);
        r = $urandom_range(0, 4095);
        case ($urandom_range(0, 5))
          0, 1, 2: addr[k] = 32'(PB[k]) + 32'(4 * r);
          3:       addr[k] = 32'(PB[k]) + 32'(4 * r) + 32'($urandom_range(1, 3));
          4:       addr[k] = 32'(PB[k]) + 32'h4000 + 32'(4 * r);
          default: addr[k] = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFC : 32'(4 * $urandom_range(0, 1023));
        endcase
      end
      sample();
      for (int k = 0; k < 3; k++) begin
        vecs++;
        if (act(k) !== ev[k]) begin
          $display("FAIL random u%0d cycle %0d: got %h expected %h", k, c, act(k), ev[k]); miss++;
        end
      end
      next_cycle();
    end
    idle_all();
  endtask

  initial begin
    reset_n = 1'b0;
    idle_all();
    for (int i = 0; i < 4096; i++) smem[i] = $urandom;
    smem[4] = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_stream();
    test_gnt_delay();
    test_busy();
    test_errors();
    test_back_to_back();
    test_reset_flight();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
